// File: rtl/alu_operand_b_stage.sv
// ALU operand-B source select with a one-entry valid/ready output register.
// Illegal selects yield a zero operand and raise a sticky error flag.
module alu_operand_b_stage #(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int SHIFT_AMT = 2,
    parameter int CONST_INC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [IMM_W-1:0]  imm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sel_err,
    input  logic              err_clr
);

    localparam int PAD = DATA_W - IMM_W;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              err_q;
    logic              illegal;
    logic              capture;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_high;

    assign imm_sext = {{PAD{imm_in[IMM_W-1]}}, imm_in};
    assign imm_zext = {{PAD{1'b0}}, imm_in};
    assign imm_high = {imm_in, {PAD{1'b0}}};

    assign in_ready  = (state_q == EMPTY) || out_ready;
    assign capture   = in_valid && in_ready;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign sel_err   = err_q;

    always_comb begin
        data_d  = '0;
        illegal = 1'b0;
        unique case (sel)
            3'b000: data_d = b_in;
            3'b001: data_d = DATA_W'(CONST_INC);
            3'b010: data_d = imm_sext;
            3'b011: data_d = imm_sext << SHIFT_AMT;
            3'b100: data_d = a_in;
            3'b101: data_d = imm_zext;
            3'b110: data_d = imm_high;
            3'b111: illegal = 1'b1;
        endcase
    end

    // A capture while FULL doubles as the consume, so the stage never bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (capture) begin
                state_q <= FULL;
                data_q  <= data_d;
            end else if (out_ready) begin
                state_q <= EMPTY;
            end
            if (capture && illegal) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Randomized bench for alu_operand_b_stage against an arithmetic reference model.
// Directed literal cases pin the model; a negedge process compares every cycle.
module tb_alu_operand_b_stage;

    localparam int SH  = 2;
    localparam int INC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  sel = 3'd0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [15:0] imm_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        sel_err;
    logic        err_clr = 1'b0;

    logic        iv64 = 1'b0;
    logic        ir64;
    logic [2:0]  sel64 = 3'd0;
    logic [15:0] imm64 = '0;
    logic        ov64;
    logic [63:0] od64;
    logic        err64;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic        m_valid = 1'b0;
    logic [63:0] m_data = '0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    alu_operand_b_stage #(
        .DATA_W(32), .IMM_W(16), .SHIFT_AMT(SH), .CONST_INC(INC)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .a_in(a_in), .b_in(b_in), .imm_in(imm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sel_err(sel_err), .err_clr(err_clr)
    );

    alu_operand_b_stage #(
        .DATA_W(64), .IMM_W(16), .SHIFT_AMT(SH), .CONST_INC(INC)
    ) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(iv64), .in_ready(ir64),
        .sel(sel64), .a_in(64'd0), .b_in(64'd0), .imm_in(imm64),
        .out_valid(ov64), .out_ready(1'b1),
        .out_data(od64), .sel_err(err64), .err_clr(1'b0)
    );

    function automatic logic [63:0] exp_op(int dw, int iw, logic [2:0] s,
                                           logic [63:0] a, logic [63:0] b,
                                           logic [63:0] imm);
        longint      sv;
        logic [63:0] r;
        logic [63:0] mask;
        mask = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
        sv = longint'(imm);
        if (imm >= (64'd1 << (iw - 1))) sv = sv - (longint'(1) << iw);
        case (s)
            3'd0: r = b;
            3'd1: r = 64'(INC);
            3'd2: r = 64'(sv);
            3'd3: r = 64'(sv * (longint'(1) << SH));
            3'd4: r = a;
            3'd5: r = imm;
            3'd6: r = imm * (64'd1 << (dw - iw));
            default: r = '0;
        endcase
        return r & mask;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one-deep buffer with sticky error, from the rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
        end else begin
            logic rdy;
            logic cap;
            rdy = !m_valid || out_ready;
            cap = in_valid && rdy;
            if (cap && sel == 3'd7) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (cap) begin
                m_valid = 1'b1;
                m_data = exp_op(32, 16, sel, 64'(a_in), 64'(b_in),
                                64'(imm_in));
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("cyc_valid", 64'(out_valid), 64'(m_valid));
            chk("cyc_data", 64'(out_data), m_data);
            chk("cyc_err", 64'(sel_err), 64'(m_err));
            chk("cyc_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic v, logic [2:0] s, logic [31:0] a,
                         logic [15:0] imm, logic ordy, logic ec);
        in_valid  = v;
        sel       = s;
        a_in      = a;
        imm_in    = imm;
        out_ready = ordy;
        err_clr   = ec;
    endtask

    initial begin
        // Request presented during reset must be dropped.
        drive(1'b1, 3'd4, 32'h1111_2222, 16'h0, 1'b0, 1'b0);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_err", 64'(sel_err), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        chk("rst_drop", 64'(out_valid), 64'd0);
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk_en = 1'b1;
        tick();
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        drive(1'b1, 3'd2, 32'h0, 16'h8004, 1'b1, 1'b0);
        tick();
        chk("sext_valid", 64'(out_valid), 64'd1);
        chk("sext_data", 64'(out_data), 64'hFFFF_8004);
        drive(1'b1, 3'd3, 32'h0, 16'h8001, 1'b1, 1'b0);
        tick();
        chk("shift_data", 64'(out_data), 64'hFFFE_0004);
        drive(1'b1, 3'd6, 32'h0, 16'h1234, 1'b1, 1'b0);
        tick();
        chk("high_data", 64'(out_data), 64'h1234_0000);
        drive(1'b1, 3'd1, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("const_data", 64'(out_data), 64'h4);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd4, $urandom, 16'(i), 1'b0, 1'b0);
            tick();
            chk("stall_data", 64'(out_data), 64'h4);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_ready", 64'(in_ready), 64'd0);
        end
        drive(1'b1, 3'd4, 32'hDEAD_BEEF, 16'h0, 1'b1, 1'b0);
        tick();
        chk("a_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("a_valid", 64'(out_valid), 64'd1);

        drive(1'b1, 3'd7, 32'h5, 16'h5, 1'b1, 1'b1);
        tick();
        chk("ill_data", 64'(out_data), 64'd0);
        chk("ill_err", 64'(sel_err), 64'd1);
        chk("ill_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 3'd7, 32'h0, 16'h0, 1'b1, 1'b1);
        tick();
        chk("clr_err", 64'(sel_err), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
        err_clr = 1'b0;

        drive(1'b1, 3'd4, 32'h55, 16'h0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("hold_data", 64'(out_data), 64'h55);
        #1 reset = 1'b1;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_data", 64'(out_data), 64'd0);
        chk("async_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        iv64 = 1'b1;
        sel64 = 3'd2;
        imm64 = 16'hFFFF;
        tick();
        chk("w64_sext", od64, 64'hFFFF_FFFF_FFFF_FFFF);
        sel64 = 3'd5;
        tick();
        chk("w64_zext", od64, 64'h0000_0000_0000_FFFF);
        sel64 = 3'd3;
        imm64 = 16'h8001;
        tick();
        chk("w64_shift", od64, 64'hFFFF_FFFF_FFFE_0004);
        iv64 = 1'b0;

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom),
                  $urandom, 16'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0));
            b_in = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
